load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 29 ++
 rtl/mem_lane.sv | 61 ++++++
 rtl/load_store_unit.sv | 98 +++++++++
 tb/tb_load_store_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared access-type and state encodings for the load/store unit, plus the
// request legality check applied at accept time.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LOAD_WAIT = 2'd1;
    localparam logic [1:0] ST_RMW_READ  = 2'd2;
    localparam logic [1:0] ST_RMW_WRITE = 2'd3;

    // Unsigned variants only make sense for loads; halves and words must be aligned.
    function automatic logic access_ok(input logic is_store, input logic [2:0] f3,
                                       input logic [1:0] lane);
        case (f3)
            F3_B:    access_ok = 1'b1;
            F3_H:    access_ok = ~lane[0];
            F3_W:    access_ok = (lane == 2'b00);
            F3_BU:   access_ok = ~is_store;
            F3_HU:   access_ok = ~is_store & ~lane[0];
            default: access_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte/half lane handling: extracts and extends load data from a RAM word and
// merges store data into a RAM word for read-modify-write.
module mem_lane
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rd_word[7:0];
        case (lane)
            2'd0: byte_sel = rd_word[7:0];
            2'd1: byte_sel = rd_word[15:8];
            2'd2: byte_sel = rd_word[23:16];
            2'd3: byte_sel = rd_word[31:24];
            default: byte_sel = rd_word[7:0];
        endcase
        half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
    end

    always_comb begin
        load_data = rd_word;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        merge_word = rd_word;
        case (funct3)
            F3_B: begin
                case (lane)
                    2'd0: merge_word[7:0]   = wdata[7:0];
                    2'd1: merge_word[15:8]  = wdata[7:0];
                    2'd2: merge_word[23:16] = wdata[7:0];
                    2'd3: merge_word[31:24] = wdata[7:0];
                    default: merge_word = rd_word;
                endcase
            end
            F3_H: begin
                if (lane[1]) merge_word[31:16] = wdata[15:0];
                else         merge_word[15:0]  = wdata[15:0];
            end
            F3_W:    merge_word = wdata;
            default: merge_word = rd_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-port load/store unit: sub-word loads with extension and sub-word
// stores via read-modify-write against a word RAM with one-cycle read latency.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [2:0]  ram_size,
    output logic [31:0] ram_wd,
    input  logic [31:0] ram_rd,
    output logic [1:0]  state
);

    // Handshake: a request transfers on any rising edge where req=1 and ready=1;
    // ready is high only in IDLE, and req is ignored otherwise.

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [2:0]  funct3_q;
    logic        done_ld_q, err_q;
    logic        accept, ok;
    logic [31:0] load_data, merge_word;

    assign ready  = (state_q == ST_IDLE);
    assign accept = req & ready;
    assign ok     = access_ok(we, funct3, addr[1:0]);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && ok) begin
                    if (!we)              state_d = ST_LOAD_WAIT;
                    else if (funct3 == F3_W) state_d = ST_RMW_WRITE;
                    else                  state_d = ST_RMW_READ;
                end
            end
            ST_LOAD_WAIT: state_d = ST_IDLE;
            ST_RMW_READ:  state_d = ST_RMW_WRITE;
            ST_RMW_WRITE: state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            funct3_q  <= '0;
            done_ld_q <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            done_ld_q <= (state_q == ST_LOAD_WAIT);
            err_q     <= accept & ~ok;
            if (accept) begin
                addr_q   <= addr;
                wdata_q  <= wdata;
                funct3_q <= funct3;
            end
            if (done_ld_q) rdata_q <= load_data;
        end
    end

    mem_lane u_mem_lane (
        .funct3     (funct3_q),
        .lane       (addr_q[1:0]),
        .rd_word    (ram_rd),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_word (merge_word)
    );

    // Load data arrives the cycle after LOAD_WAIT, so it is forwarded straight
    // from the RAM word and latched for holding afterwards.
    assign rdata    = done_ld_q ? load_data : rdata_q;
    assign done     = done_ld_q | (state_q == ST_RMW_WRITE);
    assign err      = err_q;
    assign ram_we   = (state_q == ST_RMW_WRITE);
    assign ram_addr = addr_q;
    assign ram_size = F3_W;
    assign ram_wd   = merge_word;
    assign state    = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of the load/store unit against a behavioural
// word RAM and an independent lane model.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk, rstn, req, we;
    logic [31:0] addr, wdata;
    logic [2:0]  funct3;
    logic        ready, done, err, ram_we;
    logic [31:0] rdata, ram_addr, ram_wd, ram_rd;
    logic [2:0]  ram_size;
    logic [1:0]  state;

    logic [31:0] ram [0:63];
    logic        poke_en;
    logic [5:0]  poke_idx;
    logic [31:0] poke_val;

    int we_cnt, done_cnt, n_vec, n_bad;
    logic [31:0] exp_q[$];
    logic [2:0]  f3_tbl [5];

    load_store_unit dut (
        .clk(clk), .rstn(rstn), .req(req), .we(we), .addr(addr), .funct3(funct3),
        .wdata(wdata), .ready(ready), .done(done), .rdata(rdata), .err(err),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_size(ram_size), .ram_wd(ram_wd),
        .ram_rd(ram_rd), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (poke_en) ram[poke_idx] <= poke_val;
        else if (ram_we) ram[ram_addr[7:2]] <= ram_wd;
        ram_rd <= ram[ram_addr[7:2]];
    end

    always @(negedge clk) begin
        if (ram_we) we_cnt <= we_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] ln,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[int'(ln) * 8 +: 8];
        h = w[int'(ln[1]) * 16 +: 16];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec = n_vec + 1;
        assert (obs === expv) else begin
            n_bad = n_bad + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge clk);
        poke_en = 1'b1; poke_idx = idx[5:0]; poke_val = val;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    // lat = cycles from accept edge to done/err (0 if neither within the bound).
    task automatic access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic hold, output int lat,
                          output logic got_err, output logic [31:0] rd, output int rdy_hi);
        @(negedge clk);
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk);
        #1;
        if (!hold) req = 1'b0;
        lat = 0; got_err = 1'b0; rd = '0; rdy_hi = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(negedge clk);
            if (done) begin lat = i; rd = rdata; end
            else if (err) begin lat = i; got_err = 1'b1; end
            else if (ready) rdy_hi++;
        end
        req = 1'b0;
    endtask

    int          lat, rdy_hi, wb, db;
    logic        got_err;
    logic [31:0] rd, word, expv;

    initial begin
        rstn = 1'b0; req = 1'b0; we = 1'b0; addr = '0; funct3 = '0; wdata = '0;
        poke_en = 1'b0; poke_idx = '0; poke_val = '0;
        f3_tbl[0] = F3_B; f3_tbl[1] = F3_H; f3_tbl[2] = F3_W;
        f3_tbl[3] = F3_BU; f3_tbl[4] = F3_HU;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_state", {30'd0, state}, {30'd0, ST_IDLE});
        chk("ram_size", {29'd0, ram_size}, 32'h2);
        rstn = 1'b1;

        // LW @0x10
        poke(4, 32'hDEADBEEF);
        exp_q.push_back(32'hDEADBEEF);
        access(1'b0, F3_W, 32'h10, 32'h0, 1'b0, lat, got_err, rd, rdy_hi);
        chk("lw_latency", lat, 32'd2);
        chk("lw_rdata", rd, exp_q.pop_front());
        @(negedge clk);
        chk("lw_done_width", {31'd0, done}, 32'd0);
        chk("lw_rdata_hold", rdata, 32'hDEADBEEF);

        // LB / LBU @0x13
        poke(4, 32'h80FF_0000);
        exp_q.push_back(32'hFFFFFF80);
        access(1'b0, F3_B, 32'h13, 32'h0, 1'b0, lat, got_err, rd, rdy_hi);
        chk("lb_rdata", rd, exp_q.pop_front());
        exp_q.push_back(32'h00000080);
        access(1'b0, F3_BU, 32'h13, 32'h0, 1'b0, lat, got_err, rd, rdy_hi);
        chk("lbu_rdata", rd, exp_q.pop_front());
        exp_q.push_back(32'hFFFF80FF);
        access(1'b0, F3_H, 32'h12, 32'h0, 1'b0, lat, got_err, rd, rdy_hi);
        chk("lh_rdata", rd, exp_q.pop_front());
        exp_q.push_back(32'h000080FF);
        access(1'b0, F3_HU, 32'h12, 32'h0, 1'b0, lat, got_err, rd, rdy_hi);
        chk("lhu_rdata", rd, exp_q.pop_front());

        // SB 0xAA @0x21
        poke(8, 32'h11223344);
        wb = we_cnt;
        exp_q.push_back(32'h1122AA44);
        access(1'b1, F3_B, 32'h21, 32'h1234_56AA, 1'b0, lat, got_err, rd, rdy_hi);
        chk("sb_latency", lat, 32'd2);
        @(negedge clk);
        chk("sb_word", ram[8], exp_q.pop_front());
        chk("sb_we_pulses", we_cnt - wb, 32'd1);

        // SH 0xBEEF @0x22
        poke(8, 32'h11223344);
        exp_q.push_back(32'hBEEF3344);
        access(1'b1, F3_H, 32'h22, 32'h0000BEEF, 1'b0, lat, got_err, rd, rdy_hi);
        @(negedge clk);
        chk("sh_word", ram[8], exp_q.pop_front());

        // SW: single write cycle
        wb = we_cnt;
        exp_q.push_back(32'hCAFEF00D);
        access(1'b1, F3_W, 32'h24, 32'hCAFEF00D, 1'b0, lat, got_err, rd, rdy_hi);
        chk("sw_latency", lat, 32'd1);
        @(negedge clk);
        chk("sw_word", ram[9], exp_q.pop_front());
        chk("sw_we_pulses", we_cnt - wb, 32'd1);

        // LH @0x03: misaligned
        wb = we_cnt; db = done_cnt;
        access(1'b0, F3_H, 32'h03, 32'h0, 1'b0, lat, got_err, rd, rdy_hi);
        chk("lh_mis_err", {31'd0, got_err}, 32'd1);
        chk("lh_mis_latency", lat, 32'd1);
        chk("lh_mis_ready", {31'd0, ready}, 32'd1);
        @(negedge clk);
        chk("lh_mis_err_width", {31'd0, err}, 32'd0);
        chk("lh_mis_no_we", we_cnt - wb, 32'd0);
        chk("lh_mis_no_done", done_cnt - db, 32'd0);

        // Illegal store types
        wb = we_cnt;
        access(1'b1, F3_BU, 32'h20, 32'h0, 1'b0, lat, got_err, rd, rdy_hi);
        chk("sbu_illegal_err", {31'd0, got_err}, 32'd1);
        access(1'b1, F3_W, 32'h22, 32'h0, 1'b0, lat, got_err, rd, rdy_hi);
        chk("sw_mis_err", {31'd0, got_err}, 32'd1);
        access(1'b0, 3'b011, 32'h20, 32'h0, 1'b0, lat, got_err, rd, rdy_hi);
        chk("f3_011_err", {31'd0, got_err}, 32'd1);
        @(negedge clk);
        chk("illegal_no_we", we_cnt - wb, 32'd0);
        chk("illegal_ram_word", ram[8], 32'hBEEF3344);

        // Reset during RMW_READ
        poke(8, 32'h11223344);
        wb = we_cnt;
        @(negedge clk);
        req = 1'b1; we = 1'b1; funct3 = F3_B; addr = 32'h21; wdata = 32'hAA;
        @(posedge clk);
        #1 req = 1'b0;
        chk("rmw_read_state", {30'd0, state}, {30'd0, ST_RMW_READ});
        chk("rmw_read_no_we", {31'd0, ram_we}, 32'd0);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, ready}, 32'd1);
        chk("midrst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        chk("midrst_ram_addr", ram_addr, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_no_we", we_cnt - wb, 32'd0);
        chk("midrst_word", ram[8], 32'h11223344);
        chk("midrst_state", {30'd0, state}, {30'd0, ST_IDLE});

        // req held high through a sub-word store
        poke(10, 32'h0);
        wb = we_cnt; db = done_cnt;
        exp_q.push_back(32'h0000_5500);
        access(1'b1, F3_B, 32'h29, 32'h55, 1'b1, lat, got_err, rd, rdy_hi);
        chk("hold_latency", lat, 32'd2);
        chk("hold_ready_low", rdy_hi, 32'd0);
        repeat (3) @(negedge clk);
        chk("hold_word", ram[10], exp_q.pop_front());
        chk("hold_we_pulses", we_cnt - wb, 32'd1);
        chk("hold_done_pulses", done_cnt - db, 32'd1);

        // Random legal loads
        for (int k = 0; k < 8; k++) begin
            int          idx;
            logic [2:0]  f3;
            logic [1:0]  ln;
            idx  = $urandom_range(16, 31);
            word = $urandom;
            f3   = f3_tbl[$urandom_range(0, 4)];
            ln   = 2'($urandom_range(0, 3));
            if (f3 == F3_H || f3 == F3_HU) ln[0] = 1'b0;
            if (f3 == F3_W) ln = 2'b00;
            poke(idx, word);
            expv = model_load(f3, ln, word);
            exp_q.push_back(expv);
            access(1'b0, f3, {24'd0, 6'(idx), ln}, 32'h0, 1'b0, lat, got_err, rd, rdy_hi);
            chk($sformatf("rand_load_%0d", k), rd, exp_q.pop_front());
        end

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
